// File: rtl/mp_reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

   typedef enum logic {CLEAR, RUN} rf_state_e;

   localparam int ZERO_ADDR = 0;

   function automatic int addr_width(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mp_reg_file_if.sv
// Decode/writeback-side bus of the register file; master is the pipeline, slave the file.
interface mp_reg_file_if
   import rf_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
) ();

   localparam int AW = addr_width(DEPTH);

   logic [NUM_RD*AW-1:0]    rd_addr;
   logic [NUM_RD*WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]       rd_pend;
   logic [NUM_WR-1:0]       wr_en;
   logic [NUM_WR*AW-1:0]    wr_addr;
   logic [NUM_WR*WIDTH-1:0] wr_data;
   logic                    alloc_en;
   logic [AW-1:0]           alloc_addr;
   logic                    ready;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
      input  rd_data, rd_pend, ready
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
      output rd_data, rd_pend, ready
   );

endinterface

// File: rtl/mp_reg_file_read_port.sv
// One read port: zero-register override, highest-port bypass and pending masking.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int AW       = 5,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [AW-1:0]           addr,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0]        mem_word,
   input  logic                    pend_bit,
   output logic [WIDTH-1:0]        rd_data,
   output logic                    rd_pend
);

   logic hit;
   logic is_zero;

   // Later write ports overwrite earlier matches, so the highest index wins.
   always_comb begin
      is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_ADDR));
      rd_data = mem_word;
      hit     = 1'b0;
      if (BYPASS != 0) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
               rd_data = wr_data[w*WIDTH +: WIDTH];
               hit     = 1'b1;
            end
         end
      end
      if (is_zero) begin
         rd_data = '0;
         hit     = 1'b0;
      end
      rd_pend = pend_bit && !hit && !is_zero;
   end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port register file with write bypass, pending scoreboard and sequential clear after reset.
module mp_reg_file
   import rf_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst,
   mp_reg_file_if.slave  bus
);

   localparam int AW = addr_width(DEPTH);

   logic [WIDTH-1:0]        mem [DEPTH];
   logic [DEPTH-1:0]        pend;
   rf_state_e               state;
   logic [AW-1:0]           clr_idx;
   logic                    ready_q;
   logic                    run;
   logic [WIDTH-1:0]        port_data [NUM_RD];
   logic [NUM_RD-1:0]       port_pend;
   logic [NUM_RD*WIDTH-1:0] rd_data_all;
   logic [NUM_RD-1:0]       rd_pend_all;

   assign run = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_idx <= clr_idx + AW'(1);
               if (clr_idx == AW'(DEPTH - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: ;
            default: begin
               state   <= CLEAR;
               clr_idx <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage is left alone on the reset edge; the CLEAR walk zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_idx] <= '0;
         end else if (run) begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (bus.wr_en[w] &&
                   !((ZERO_REG != 0) && (bus.wr_addr[w*AW +: AW] == AW'(ZERO_ADDR)))) begin
                  mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   // Allocation is applied after the write clears so a newer producer keeps its bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else if (run) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w]) pend[bus.wr_addr[w*AW +: AW]] <= 1'b0;
         end
         if (bus.alloc_en &&
             !((ZERO_REG != 0) && (bus.alloc_addr == AW'(ZERO_ADDR)))) begin
            pend[bus.alloc_addr] <= 1'b1;
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = bus.rd_addr[p*AW +: AW];

      rf_read_port #(
         .WIDTH    (WIDTH),
         .AW       (AW),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_port (
         .addr     (addr),
         .wr_en    (bus.wr_en),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .mem_word (mem[addr]),
         .pend_bit (pend[addr]),
         .rd_data  (port_data[p]),
         .rd_pend  (port_pend[p])
      );
   end

   always_comb begin
      rd_data_all = '0;
      rd_pend_all = '0;
      if (run) begin
         for (int p = 0; p < NUM_RD; p++) begin
            rd_data_all[p*WIDTH +: WIDTH] = port_data[p];
            rd_pend_all[p]                = port_pend[p];
         end
      end
   end

   assign bus.rd_data = rd_data_all;
   assign bus.rd_pend = rd_pend_all;
   assign bus.ready   = ready_q;

endmodule

// File: tb/tb_mp_reg_file.sv
// Scoreboard bench for mp_reg_file: one bypassing and one non-bypassing instance share stimulus.
module tb_mp_reg_file;

   localparam int S_DATA0  = 0;
   localparam int S_DATA1  = 1;
   localparam int S_PEND0  = 2;
   localparam int S_PEND1  = 3;
   localparam int S_READY  = 4;
   localparam int S_BDATA0 = 5;
   localparam int S_BPEND0 = 6;
   localparam int S_BREADY = 7;

   typedef struct {
      int          cyc;
      string       name;
      int          sel;
      logic [31:0] exp;
   } sb_entry_t;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        alloc_en;
   logic [4:0]  alloc_addr;

   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   sb_entry_t   sb_q[$];

   mp_reg_file_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
   mp_reg_file_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_b ();

   assign bus_a.rd_addr    = rd_addr;
   assign bus_a.wr_en      = wr_en;
   assign bus_a.wr_addr    = wr_addr;
   assign bus_a.wr_data    = wr_data;
   assign bus_a.alloc_en   = alloc_en;
   assign bus_a.alloc_addr = alloc_addr;
   assign bus_b.rd_addr    = rd_addr;
   assign bus_b.wr_en      = wr_en;
   assign bus_b.wr_addr    = wr_addr;
   assign bus_b.wr_data    = wr_data;
   assign bus_b.alloc_en   = alloc_en;
   assign bus_b.alloc_addr = alloc_addr;

   mp_reg_file #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   mp_reg_file #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_obs(input int sel);
      case (sel)
         S_DATA0:  return bus_a.rd_data[31:0];
         S_DATA1:  return bus_a.rd_data[63:32];
         S_PEND0:  return {31'b0, bus_a.rd_pend[0]};
         S_PEND1:  return {31'b0, bus_a.rd_pend[1]};
         S_READY:  return {31'b0, bus_a.ready};
         S_BDATA0: return bus_b.rd_data[31:0];
         S_BPEND0: return {31'b0, bus_b.rd_pend[0]};
         S_BREADY: return {31'b0, bus_b.ready};
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: drains every expectation queued for the current cycle, mid-cycle.
   always @(negedge clk) begin
      sb_entry_t e;
      logic [31:0] obs;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e   = sb_q.pop_front();
         obs = get_obs(e.sel);
         vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, obs, e.exp, e.cyc);
         end
      end
   end

   task automatic check_output(input string name, input int sel, input logic [31:0] exp);
      sb_entry_t e;
      e.cyc  = cyc;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic ae, input logic [4:0] aa,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en      = we;
      wr_addr    = {wa1, wa0};
      wr_data    = {wd1, wd0};
      alloc_en   = ae;
      alloc_addr = aa;
      rd_addr    = {ra1, ra0};
   endtask

   task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
      apply_stimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
   endtask

   // Walks the whole CLEAR phase from clr_idx 0; noisy mode hammers r2 with writes and allocs.
   task automatic run_clear(input logic noisy);
      for (int i = 0; i < 32; i++) begin
         if (noisy) apply_stimulus(2'b11, 5'd2, 32'h0BAD, 5'd31, 32'h0BAD, 1'b1, 5'd2, 5'd2, 5'd31);
         else       idle(5'd1, 5'd2);
         check_output("clear_ready_low", S_READY, 32'd0);
         if (noisy) begin
            check_output("clear_rd_data_zero", S_DATA0, 32'd0);
            check_output("clear_rd_pend_zero", S_PEND0, 32'd0);
         end
         tick();
      end
      check_output("ready_rise", S_READY, 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle(5'd0, 5'd0);
      tick();
      rst = 1'b0;
      check_output("reset_ready", S_READY, 32'd0);
      check_output("reset_pend0", S_PEND0, 32'd0);
      check_output("reset_pend1", S_PEND1, 32'd0);
      check_output("reset_data0", S_DATA0, 32'd0);
      run_clear(1'b0);

      // Preload, then a one-cycle reset pulse must wipe everything.
      apply_stimulus(2'b11, 5'd1, 32'h1111, 5'd2, 32'h2222, 1'b1, 5'd6, 5'd1, 5'd2);
      tick();
      idle(5'd1, 5'd2);
      check_output("preload_r1", S_DATA0, 32'h1111);
      check_output("preload_r2", S_DATA1, 32'h2222);
      tick();
      idle(5'd6, 5'd2);
      check_output("preload_pend_r6", S_PEND0, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(5'd1, 5'd6);
      check_output("pulse_ready_low", S_READY, 32'd0);
      check_output("pulse_data_gated", S_DATA0, 32'd0);
      run_clear(1'b1);
      for (int i = 0; i < 16; i++) begin
         idle(5'(2 * i), 5'(2 * i + 1));
         check_output("cleared_data0", S_DATA0, 32'd0);
         check_output("cleared_data1", S_DATA1, 32'd0);
         check_output("cleared_pend0", S_PEND0, 32'd0);
         check_output("cleared_pend1", S_PEND1, 32'd0);
         tick();
      end

      // Basic write then read, with r0 on the second port.
      apply_stimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      check_output("bypass_r5", S_DATA0, 32'hDEADBEEF);
      check_output("nobypass_r5_old", S_BDATA0, 32'd0);
      tick();
      idle(5'd5, 5'd0);
      check_output("read_r5", S_DATA0, 32'hDEADBEEF);
      check_output("read_r0", S_DATA1, 32'd0);
      check_output("nobypass_read_r5", S_BDATA0, 32'hDEADBEEF);
      tick();

      // Two ports write r7 together; port 1 must win.
      apply_stimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
      check_output("prio_bypass_p0", S_DATA0, 32'h22);
      check_output("prio_bypass_p1", S_DATA1, 32'h22);
      check_output("prio_nobypass_old", S_BDATA0, 32'd0);
      tick();
      idle(5'd7, 5'd5);
      check_output("prio_stored", S_DATA0, 32'h22);
      check_output("prio_stored_b", S_BDATA0, 32'h22);
      tick();

      // Scoreboard: alloc, observe pending, write clears it.
      apply_stimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
      check_output("alloc_cycle_pend", S_PEND0, 32'd0);
      tick();
      idle(5'd3, 5'd0);
      check_output("pend_r3_set", S_PEND0, 32'd1);
      check_output("pend_r3_set_b", S_BPEND0, 32'd1);
      tick();
      apply_stimulus(2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      check_output("pend_masked", S_PEND0, 32'd0);
      check_output("pend_bypass_data", S_DATA0, 32'h5);
      check_output("pend_nomask_b", S_BPEND0, 32'd1);
      check_output("pend_old_data_b", S_BDATA0, 32'd0);
      tick();
      idle(5'd3, 5'd0);
      check_output("pend_r3_clear", S_PEND0, 32'd0);
      check_output("pend_r3_data", S_DATA0, 32'h5);
      check_output("pend_r3_clear_b", S_BPEND0, 32'd0);
      tick();

      // Alloc and write to r9 together: the alloc wins.
      apply_stimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd0);
      check_output("collide_bypass", S_DATA0, 32'h77);
      check_output("collide_pend_masked", S_PEND0, 32'd0);
      tick();
      idle(5'd9, 5'd0);
      check_output("collide_data", S_DATA0, 32'h77);
      check_output("collide_pend", S_PEND0, 32'd1);
      check_output("collide_pend_b", S_BPEND0, 32'd1);
      tick();

      // Register 0 ignores writes and allocs.
      apply_stimulus(2'b11, 5'd0, 32'hFF, 5'd0, 32'hFF, 1'b1, 5'd0, 5'd0, 5'd0);
      check_output("r0_no_bypass0", S_DATA0, 32'd0);
      check_output("r0_no_bypass1", S_DATA1, 32'd0);
      check_output("r0_pend", S_PEND0, 32'd0);
      check_output("r0_no_bypass_b", S_BDATA0, 32'd0);
      tick();
      idle(5'd0, 5'd9);
      check_output("r0_data", S_DATA0, 32'd0);
      check_output("r0_pend_after", S_PEND0, 32'd0);
      check_output("r0_data_b", S_BDATA0, 32'd0);
      check_output("r9_still_pend", S_PEND1, 32'd1);
      tick();

      // Reset again at clear cycle 10; the walk must restart from scratch.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         idle(5'd9, 5'd3);
         check_output("midclear_ready_low", S_READY, 32'd0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_clear(1'b0);
      check_output("midclear_ready_b", S_BREADY, 32'd1);
      idle(5'd9, 5'd3);
      check_output("midclear_r9_data", S_DATA0, 32'd0);
      check_output("midclear_r9_pend", S_PEND0, 32'd0);
      check_output("midclear_r3_data", S_DATA1, 32'd0);
      check_output("midclear_r9_pend_b", S_BPEND0, 32'd0);
      tick();
      idle(5'd5, 5'd7);
      check_output("midclear_r5_data", S_DATA0, 32'd0);
      check_output("midclear_r7_data", S_DATA1, 32'd0);
      tick();
      tick();

      if (sb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mp_reg_file.md
Name: mp_reg_file

Overview:
Parametrised multi-port register file, the successor to the single-write, dual-read pipeline register file. It adds configurable read/write port counts, same-cycle write-to-read bypass and a per-register pending scoreboard for hazard detection. It also clears storage sequentially after reset instead of with a one-cycle wide clear. It sits between decode (read and allocate) and writeback (write) in the pipeline core.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 32, number of registers; power of two, at least 4
NUM_RD, 2, number of read ports, 1..4
NUM_WR, 1, number of write ports, 1..2
ZERO_REG, 1, when 1, register 0 is hardwired to zero
BYPASS, 1, when 1, same-cycle writes are forwarded to reads

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*log2(DEPTH)  read addresses; port p occupies slice p
rd_data  out  NUM_RD*WIDTH  read data, combinational
rd_pend  out  NUM_RD  register addressed by port p has an outstanding producer
wr_en  in  NUM_WR  write enable per port
wr_addr  in  NUM_WR*log2(DEPTH)  write addresses
wr_data  in  NUM_WR*WIDTH  write data
alloc_en  in  1  mark alloc_addr as pending (a new producer has been issued)
alloc_addr  in  log2(DEPTH)  register being allocated
ready  out  1  high once clearing is done and normal operation has begun

Behaviour:
- FSM states: CLEAR, RUN. The current state is visible on ready (ready=1 only in RUN).
- While rst=1 at a clock edge:
  - state<=CLEAR, clr_idx<=0, ready<=0.
  - All pending bits <=0 in the same edge.
  - Storage is not touched in this edge.
- CLEAR state:
  - Each cycle, mem[clr_idx]<=0 and clr_idx increments.
  - When clr_idx==DEPTH-1 is written, the next state is RUN and ready rises on the following edge. Clearing therefore takes exactly DEPTH cycles after rst deasserts.
  - wr_en and alloc_en are ignored.
  - rd_data reads 0 and rd_pend reads 0.
- rst asserted mid-CLEAR restarts clr_idx at 0. rst asserted in RUN re-enters CLEAR.
- RUN, writes:
  - When wr_en[w] is set, mem[wr_addr[w]]<=wr_data[w] at the edge.
  - If two ports write the same address in one cycle, the higher port index wins.
- RUN, reads: rd_data[p] is combinational and resolved as follows:
  - ZERO_REG=1 and address 0: returns 0.
  - Otherwise, BYPASS=1 and some wr_en[w] with wr_addr[w]==rd_addr[p]: returns wr_data of the highest matching w.
  - Otherwise: returns mem[rd_addr[p]].
- BYPASS=0: a read in the same cycle as a write to that address returns the old value. The new value is visible from the next cycle.
- Scoreboard: one pending bit per register.
  - alloc_en sets pend[alloc_addr].
  - A write clears pend[wr_addr].
  - If alloc and write hit the same address in one cycle, alloc wins and the bit stays set (the newer producer).
  - rd_pend[p] = pend[rd_addr[p]] AND NOT (BYPASS and a same-cycle write matches rd_addr[p]).
- ZERO_REG=1:
  - Writes to address 0 are dropped and never bypassed.
  - alloc to address 0 is ignored, and rd_pend for address 0 is always 0.
- Address widths are exact log2(DEPTH), so no out-of-range addresses exist. Write data is stored at full WIDTH with no truncation.
- Reset values: ready=0, rd_pend=0. rd_data is 0 in every cycle except RUN.
- No $display or other simulation-only side effects in RTL.

Decomposition:
- Shared package rf_pkg:
  - state enum {CLEAR, RUN}
  - address-width helper function (ceil log2)
  - constant ZERO_ADDR=0
- One sub-module, rf_read_port, instantiated NUM_RD times:
  - inputs: address, full wr_en/wr_addr/wr_data vectors, storage word, pend bit
  - outputs: rd_data, rd_pend
  - contains the zero-register, bypass-priority and pend-masking logic
- Top level holds storage, scoreboard, clear FSM and write arbitration.

Test Plan:
1. Reset clear:
   - Stimulus: preload via writes, pulse rst for 1 cycle.
   - Required: ready=0 for exactly 32 cycles, then 1; all 32 registers read 0; writes during CLEAR are discarded.
2. Basic write/read:
   - Stimulus: write r5=0xDEADBEEF; next cycle read r5 on port 0 and r0 on port 1.
   - Required: 0xDEADBEEF and 0 respectively.
3. Bypass and write priority:
   - Stimulus: NUM_WR=2; in one cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22 while reading r7.
   - Required: BYPASS=1 reads 0x22 in that cycle; BYPASS=0 reads the old value; the stored value is 0x22.
4. Scoreboard:
   - Stimulus: alloc r3; next cycle read r3; then write r3=0x5 while reading r3.
   - Required: rd_pend=1, then rd_pend=0 with rd_data=0x5 in the write cycle (BYPASS=1); pend clear afterwards.
5. Alloc/write collision:
   - Stimulus: same cycle alloc r9 and write r9=0x77.
   - Required: mem[9]=0x77 and pend[9] stays 1. Also, alloc r0 or write r0=0xFF leaves r0 reading 0 with rd_pend=0.
6. Reset mid-clear:
   - Stimulus: assert rst at cycle 10 of CLEAR.
   - Required: clear restarts; ready rises 32 cycles after the second rst deasserts; pend bits all 0.
